// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the cached data memory: serialises CPU and
// auxiliary requests into one-cycle memread/memwrite pulses and tracks hit/miss/timeout.
module data_mem_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_sign_mask,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_sign_mask,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [31:0]       r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_sign_mask,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_stall,
  output logic              busy,
  output logic              timeout_flag,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, WAIT} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              tflag_q, tflag_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic              pick1;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  // Round-robin hands a contested slot to the port not granted last time.
  always_comb begin
    pick1 = 1'b0;
    if (ARB_MODE == 1) begin
      pick1 = ~r0_req;
    end else if (r0_req && r1_req) begin
      pick1 = ~last_q;
    end else begin
      pick1 = r1_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    tcnt_d    = tcnt_q;
    tflag_d   = tflag_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    ack       = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stall still high here belongs to an earlier command, so hold off.
        if (!mem_stall && (r0_req || r1_req)) begin
          gnt_d   = pick1;
          last_d  = pick1;
          we_d    = pick1 ? r1_we        : r0_we;
          addr_d  = pick1 ? r1_addr      : r0_addr;
          wdata_d = pick1 ? r1_wdata     : r0_wdata;
          mask_d  = pick1 ? r1_sign_mask : r0_sign_mask;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        state_d   = RESP;
      end
      RESP: begin
        if (!mem_stall) begin
          ack     = 1'b1;
          rdata   = mem_rdata;
          state_d = IDLE;
          if (hit_q != {CNT_W{1'b1}}) hit_d = hit_q + CNT_W'(1);
        end else begin
          tcnt_d  = TW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mem_stall) begin
          ack     = 1'b1;
          rdata   = mem_rdata;
          state_d = IDLE;
          if (miss_q != {CNT_W{1'b1}}) miss_d = miss_q + CNT_W'(1);
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          ack     = 1'b1;
          err     = 1'b1;
          tflag_d = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Completion is steered only to the granted port; the other port sees zeros.
  assign r0_ack   = ack & ~gnt_q;
  assign r1_ack   = ack &  gnt_q;
  assign r0_err   = err & ~gnt_q;
  assign r1_err   = err &  gnt_q;
  assign r0_rdata = gnt_q ? 32'd0 : rdata;
  assign r1_rdata = gnt_q ? rdata : 32'd0;

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_sign_mask = mask_q;
  assign busy          = (state_q != IDLE);
  assign timeout_flag  = tflag_q;
  assign hit_cnt       = hit_q;
  assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a round-robin and a fixed-priority instance
// share one set of request/memory stimulus so grant order can be compared side by side.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0Req, r0We, r1Req, r1We;
  logic [13:0] r0Addr, r1Addr;
  logic [31:0] r0Wdata, r1Wdata;
  logic [3:0]  r0Mask, r1Mask;
  logic [31:0] memRdata;
  logic        memStall;

  logic        aR0Ack, aR0Err, aR1Ack, aR1Err, aMemRead, aMemWrite, aBusy, aTflag;
  logic [31:0] aR0Rdata, aR1Rdata, aMemWdata;
  logic [13:0] aMemAddr;
  logic [3:0]  aMemMask, aHit, aMiss;

  logic        bR0Ack, bR0Err, bR1Ack, bR1Err, bMemRead, bMemWrite, bBusy, bTflag;
  logic [31:0] bR0Rdata, bR1Rdata, bMemWdata;
  logic [13:0] bMemAddr;
  logic [3:0]  bMemMask, bHit, bMiss;

  int checks;
  int errors;

  data_mem_arbiter #(.ADDR_W(14), .ARB_MODE(0), .TIMEOUT_CYC(8), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0Req), .r0_we(r0We), .r0_addr(r0Addr), .r0_wdata(r0Wdata), .r0_sign_mask(r0Mask),
    .r0_ack(aR0Ack), .r0_err(aR0Err), .r0_rdata(aR0Rdata),
    .r1_req(r1Req), .r1_we(r1We), .r1_addr(r1Addr), .r1_wdata(r1Wdata), .r1_sign_mask(r1Mask),
    .r1_ack(aR1Ack), .r1_err(aR1Err), .r1_rdata(aR1Rdata),
    .mem_addr(aMemAddr), .mem_wdata(aMemWdata), .mem_sign_mask(aMemMask),
    .mem_read(aMemRead), .mem_write(aMemWrite), .mem_rdata(memRdata), .mem_stall(memStall),
    .busy(aBusy), .timeout_flag(aTflag), .hit_cnt(aHit), .miss_cnt(aMiss)
  );

  data_mem_arbiter #(.ADDR_W(14), .ARB_MODE(1), .TIMEOUT_CYC(8), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0Req), .r0_we(r0We), .r0_addr(r0Addr), .r0_wdata(r0Wdata), .r0_sign_mask(r0Mask),
    .r0_ack(bR0Ack), .r0_err(bR0Err), .r0_rdata(bR0Rdata),
    .r1_req(r1Req), .r1_we(r1We), .r1_addr(r1Addr), .r1_wdata(r1Wdata), .r1_sign_mask(r1Mask),
    .r1_ack(bR1Ack), .r1_err(bR1Err), .r1_rdata(bR1Rdata),
    .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_sign_mask(bMemMask),
    .mem_read(bMemRead), .mem_write(bMemWrite), .mem_rdata(memRdata), .mem_stall(memStall),
    .busy(bBusy), .timeout_flag(bTflag), .hit_cnt(bHit), .miss_cnt(bMiss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [13:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask);
    if (port) begin
      r1Req = 1'b1; r1We = we; r1Addr = addr; r1Wdata = wdata; r1Mask = mask;
    end else begin
      r0Req = 1'b1; r0We = we; r0Addr = addr; r0Wdata = wdata; r0Mask = mask;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; memStall = 1'b0; memRdata = '0;
    r0Req = 0; r0We = 0; r0Addr = '0; r0Wdata = '0; r0Mask = '0;
    r1Req = 0; r1We = 0; r1Addr = '0; r1Wdata = '0; r1Mask = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset busy", aBusy, 0);
    checkOutput("reset mem_read", aMemRead, 0);
    checkOutput("reset mem_addr", aMemAddr, 0);
    checkOutput("reset hit_cnt", aHit, 0);

    // Load hit on port 0
    $display("[TB] load hit on r0");
    applyStimulus(0, 0, 14'h1004, 32'h0, 4'h2);
    #1 checkOutput("hit idle mem_read", aMemRead, 0);
    step();
    checkOutput("hit issue mem_read", aMemRead, 1);
    checkOutput("hit issue mem_write", aMemWrite, 0);
    checkOutput("hit issue mem_addr", aMemAddr, 14'h1004);
    step();
    memRdata = 32'hCAFEF00D;
    #1;
    checkOutput("hit r0_ack", aR0Ack, 1);
    checkOutput("hit r0_rdata", aR0Rdata, 32'hCAFEF00D);
    checkOutput("hit r1_rdata zero", aR1Rdata, 0);
    checkOutput("hit resp mem_read", aMemRead, 0);
    checkOutput("hit resp mem_addr hold", aMemAddr, 14'h1004);
    r0Req = 0;
    step();
    checkOutput("hit hit_cnt", aHit, 1);
    checkOutput("hit busy", aBusy, 0);

    // Store miss on port 1, stall for two cycles
    $display("[TB] store miss on r1");
    applyStimulus(1, 1, 14'h1010, 32'hDEADBEEF, 4'h5);
    step();
    checkOutput("miss issue mem_write", aMemWrite, 1);
    checkOutput("miss issue mem_read", aMemRead, 0);
    checkOutput("miss issue wdata", aMemWdata, 32'hDEADBEEF);
    checkOutput("miss issue mask", aMemMask, 4'h5);
    memStall = 1'b1;
    step();
    checkOutput("miss resp r1_ack", aR1Ack, 0);
    checkOutput("miss resp mem_write", aMemWrite, 0);
    step();
    checkOutput("miss wait r1_ack", aR1Ack, 0);
    checkOutput("miss wait mask hold", aMemMask, 4'h5);
    step();
    memStall = 1'b0;
    memRdata = 32'h11111111;
    #1;
    checkOutput("miss r1_ack", aR1Ack, 1);
    checkOutput("miss r1_err", aR1Err, 0);
    checkOutput("miss r0_ack", aR0Ack, 0);
    r1Req = 0;
    step();
    checkOutput("miss miss_cnt", aMiss, 1);
    checkOutput("miss hit_cnt", aHit, 1);

    // Both ports held: round-robin alternates, fixed priority always picks port 0
    $display("[TB] arbitration with both requesting");
    applyStimulus(0, 0, 14'h0100, 32'h0, 4'h0);
    applyStimulus(1, 0, 14'h0200, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("arb rr mem_addr", aMemAddr, (i % 2 == 1) ? 14'h0200 : 14'h0100);
      checkOutput("arb fixed mem_addr", bMemAddr, 14'h0100);
      step();
      checkOutput("arb rr r0_ack", aR0Ack, (i % 2 == 0) ? 1 : 0);
      checkOutput("arb rr r1_ack", aR1Ack, (i % 2 == 1) ? 1 : 0);
      checkOutput("arb fixed r0_ack", bR0Ack, 1);
      checkOutput("arb fixed r1_ack", bR1Ack, 0);
      if (i == 3) begin
        r0Req = 0;
        r1Req = 0;
      end
      step();
    end
    checkOutput("arb rr hit_cnt", aHit, 5);
    checkOutput("arb fixed hit_cnt", bHit, 5);

    // Stall stuck high: abort after the timeout, then no grant while stall persists
    $display("[TB] timeout abort");
    applyStimulus(0, 0, 14'h0040, 32'h0, 4'h0);
    step();
    memStall = 1'b1;
    memRdata = 32'hAAAA5555;
    step();
    for (int k = 3; k <= 8; k++) begin
      step();
      checkOutput("tmo wait r0_ack", aR0Ack, 0);
    end
    step();
    checkOutput("tmo r0_ack", aR0Ack, 1);
    checkOutput("tmo r0_err", aR0Err, 1);
    checkOutput("tmo r0_rdata", aR0Rdata, 0);
    checkOutput("tmo flag before edge", aTflag, 0);
    step();
    checkOutput("tmo flag", aTflag, 1);
    checkOutput("tmo busy", aBusy, 0);
    checkOutput("tmo miss_cnt", aMiss, 1);
    checkOutput("tmo hit_cnt", aHit, 5);
    step();
    checkOutput("tmo no grant mem_read", aMemRead, 0);
    checkOutput("tmo no grant busy", aBusy, 0);

    // Reset while in WAIT with stall high
    $display("[TB] reset during wait");
    memStall = 1'b0;
    step();
    checkOutput("rst pre issue mem_read", aMemRead, 1);
    memStall = 1'b1;
    step();
    step();
    checkOutput("rst pre wait busy", aBusy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst async busy", aBusy, 0);
    checkOutput("rst async flag", aTflag, 0);
    checkOutput("rst async mem_addr", aMemAddr, 0);
    checkOutput("rst async miss_cnt", aMiss, 0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rst held mem_read", aMemRead, 0);
    checkOutput("rst held busy", aBusy, 0);
    step();
    checkOutput("rst held2 mem_read", aMemRead, 0);
    memStall = 1'b0;
    step();
    checkOutput("rst resume mem_read", aMemRead, 1);
    checkOutput("rst resume mem_addr", aMemAddr, 14'h0040);
    step();
    checkOutput("rst resume r0_ack", aR0Ack, 1);

    // Saturation: 17 hits since reset on a 4-bit counter
    $display("[TB] hit counter saturation");
    for (int n = 2; n <= 17; n++) begin
      step();
      if (n == 15) checkOutput("sat hit_cnt 14", aHit, 14);
      if (n == 16) checkOutput("sat hit_cnt 15", aHit, 15);
      step();
      step();
      checkOutput("sat r0_ack", aR0Ack, 1);
      if (n == 17) r0Req = 0;
    end
    step();
    checkOutput("sat hit_cnt final", aHit, 15);
    checkOutput("sat fixed hit_cnt final", bHit, 15);
    checkOutput("sat miss_cnt", aMiss, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
